// File: rtl/param_sequencer.sv
// Coefficient load sequencer: fades gain to silence, loads changed filter
// indices one target at a time with an ack handshake, then fades back in.
module param_sequencer #(
    parameter int unsigned RAMP_STEP   = 8,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic       sample_tick,
    input  logic       mute,
    input  logic [2:0] freqSelect,
    input  logic [2:0] lowpassSelect,
    input  logic [2:0] highpassSelect,
    input  logic       coef_ack,
    output logic       coef_req,
    output logic [1:0] coef_target,
    output logic [2:0] coef_index,
    output logic [7:0] gain,
    output logic       busy,
    output logic       load_err
);

    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, FADE_OUT, LOAD, WAIT_ACK, FADE_IN} state_t;

    state_t          state, state_n;
    logic [7:0]      gain_n;
    logic            coef_req_n;
    logic [1:0]      coef_target_n;
    logic [2:0]      coef_index_n;
    logic            load_err_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0][2:0] applied, applied_n;
    logic [2:0][2:0] req_idx;
    logic [2:0]      pending;
    logic [1:0]      sel;

    assign req_idx = {highpassSelect, lowpassSelect, freqSelect};
    assign busy    = (state != IDLE);

    always_comb begin
        for (int unsigned t = 0; t < 3; t++) begin
            pending[t] = (req_idx[t] != applied[t]);
        end
    end

    // Moves one step toward tgt, landing exactly on tgt when closer than a step.
    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] step;
        step = 9'(RAMP_STEP);
        if (cur < tgt) begin
            return (({1'b0, tgt} - {1'b0, cur}) <= step) ? tgt : 8'({1'b0, cur} + step);
        end else if (cur > tgt) begin
            return (({1'b0, cur} - {1'b0, tgt}) <= step) ? tgt : 8'({1'b0, cur} - step);
        end
        return cur;
    endfunction

    always_comb begin
        state_n       = state;
        gain_n        = gain;
        coef_req_n    = coef_req;
        coef_target_n = coef_target;
        coef_index_n  = coef_index;
        load_err_n    = load_err;
        timer_n       = timer;
        applied_n     = applied;
        sel           = 2'd0;

        case (state)
            IDLE: begin
                if (|pending) begin
                    state_n = FADE_OUT;
                end else if (sample_tick) begin
                    gain_n = ramp(gain, mute ? 8'h00 : 8'hFF);
                end
            end
            FADE_OUT: begin
                if (gain == 8'h00) begin
                    state_n = LOAD;
                end else if (sample_tick) begin
                    gain_n = ramp(gain, 8'h00);
                end
            end
            LOAD: begin
                if (|pending) begin
                    if (pending[0])      sel = 2'd0;
                    else if (pending[1]) sel = 2'd1;
                    else                 sel = 2'd2;
                    coef_target_n = sel;
                    coef_index_n  = req_idx[sel];
                    coef_req_n    = 1'b1;
                    timer_n       = '0;
                    state_n       = WAIT_ACK;
                end else begin
                    state_n = FADE_IN;
                end
            end
            WAIT_ACK: begin
                // A timed-out load is still recorded as applied so it is not retried forever.
                if (coef_req && coef_ack) begin
                    applied_n[coef_target] = coef_index;
                    coef_req_n             = 1'b0;
                    state_n                = LOAD;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    applied_n[coef_target] = coef_index;
                    coef_req_n             = 1'b0;
                    load_err_n             = 1'b1;
                    state_n                = LOAD;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            FADE_IN: begin
                if (|pending) begin
                    state_n = FADE_OUT;
                end else if (mute) begin
                    state_n = IDLE;
                end else begin
                    if (sample_tick) gain_n = ramp(gain, 8'hFF);
                    if (gain_n == 8'hFF) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_48) begin
        if (!reset_n) begin
            state       <= IDLE;
            gain        <= '0;
            coef_req    <= 1'b0;
            coef_target <= '0;
            coef_index  <= '0;
            load_err    <= 1'b0;
            timer       <= '0;
            applied     <= '0;
        end else begin
            state       <= state_n;
            gain        <= gain_n;
            coef_req    <= coef_req_n;
            coef_target <= coef_target_n;
            coef_index  <= coef_index_n;
            load_err    <= load_err_n;
            timer       <= timer_n;
            applied     <= applied_n;
        end
    end

endmodule

// File: doc/param_sequencer.md
PARAM_SEQUENCER -- requirements
Module: param_sequencer

Interface
REQ-001 Parameter RAMP_STEP, default 8: gain change applied per sample_tick while ramping.
REQ-002 Parameter ACK_TIMEOUT, default 255: clk_48 cycles to wait for coef_ack before abandoning a load.
REQ-003 clk_48  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 sample_tick  input  1  one-cycle audio sample strobe that paces gain ramps.
REQ-006 mute  input  1  requested mute state from the button encoder.
REQ-007 freqSelect  input  3  requested EQ frequency index.
REQ-008 lowpassSelect  input  3  requested lowpass index.
REQ-009 highpassSelect  input  3  requested highpass index.
REQ-010 coef_ack  input  1  filter bank has accepted the current coefficient load.
REQ-011 coef_req  output  1  coefficient load request.
REQ-012 coef_target  output  2  load target: 0 = EQ freq, 1 = lowpass, 2 = highpass.
REQ-013 coef_index  output  3  index to load into coef_target.
REQ-014 gain  output  8  channel output gain, 0 = silent, 255 = unity.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 load_err  output  1  sticky flag: a load timed out.

Function
REQ-017 Three applied registers hold the last successfully or abandoned-loaded index per target; pending[t] SHALL equal (requested index for t != applied[t]), evaluated every cycle.
REQ-018 States: IDLE, FADE_OUT, LOAD, WAIT_ACK, FADE_IN.
REQ-019 IDLE: any pending -> FADE_OUT; otherwise gain ramps toward (mute ? 0 : 255) on each sample_tick.
REQ-020 Ramping: on sample_tick, gain moves toward its target by RAMP_STEP, saturating exactly at the target (never overshooting, never wrapping past 0 or 255); no change without sample_tick.
REQ-021 FADE_OUT: ramp toward 0; when gain == 0 -> LOAD next cycle (gain already 0 on entry: LOAD on the following cycle).
REQ-022 LOAD: select the lowest-numbered pending target; drive coef_target and coef_index (requested value sampled this cycle); assert coef_req; -> WAIT_ACK. With none pending -> FADE_IN.
REQ-023 WAIT_ACK: coef_req, coef_target and coef_index SHALL stay stable until coef_ack is sampled high, including when the select input changes meanwhile.
REQ-024 On coef_ack high in WAIT_ACK: applied[target] <= driven index; coef_req low the next cycle; -> LOAD.
REQ-025 Timeout: after ACK_TIMEOUT cycles in WAIT_ACK without ack, drop coef_req, set load_err, set applied[target] to the driven index, -> LOAD.
REQ-026 coef_ack while coef_req is low SHALL be ignored.
REQ-027 A select changing during a load of the same target leaves pending re-set after completion, so it is reloaded before FADE_IN; no update is lost.
REQ-028 FADE_IN: any pending -> FADE_OUT; mute high -> IDLE immediately (gain stays 0); otherwise ramp toward 255, -> IDLE on reaching 255.
REQ-029 Mute changes alone never trigger a load; gain stays 0 in FADE_OUT, LOAD and WAIT_ACK regardless of mute.
REQ-030 Simultaneous pending targets load in order 0, 1, 2 within one fade.

Reset
REQ-031 reset_n low at a clock edge SHALL force IDLE, gain 0, coef_req 0, coef_target 0, coef_index 0, load_err 0, and all applied registers 0, including mid-load.
REQ-032 After reset, inputs differing from 0 SHALL produce a start-up load sequence per REQ-019..REQ-028.

Verification
REQ-033 Reset with freqSelect=4, lowpassSelect=1, highpassSelect=2, mute=0, ack one cycle after req -> loads (0,4), (1,1), (2,2) in order, then gain 0->255 in 32 ticks, busy low.
REQ-034 Idle at gain 255, lowpassSelect 1->3 -> gain to 0 in 32 ticks, single load (1,3), ramp back to 255.
REQ-035 Never assert coef_ack during a highpass load -> coef_req drops after 255 cycles, load_err=1, sequence continues to FADE_IN.
REQ-036 freqSelect 1->2 during WAIT_ACK for (0,1) -> coef_index holds 1 until ack, then (0,2) loads before FADE_IN.
REQ-037 mute=1 in IDLE at gain 255 -> gain steps 247, 239, ... 7, 0 with no coef_req; mute=0 ramps back to 255.
REQ-038 reset_n low during WAIT_ACK -> next cycle coef_req 0, gain 0, IDLE; stray coef_ack afterwards has no effect.
